// File: rtl/word_stream_pkg.sv
// Shared word type and default geometry for the 10-bit word stream path.
// Used by both the FIFO and the consumer side.
package word_stream_pkg;
  localparam int unsigned WordWidth         = 10;
  localparam int unsigned DefaultDepth      = 4;
  localparam int unsigned DefaultAlmostFull = 3;

  typedef logic [WordWidth-1:0] word_t;
endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and flag registers for word_stream_fifo.
// Handshake qualification uses registered flags only, so ready never depends on the pop side.
module fifo_ptr_ctrl
  import word_stream_pkg::*;
#(
  parameter int unsigned DEPTH       = DefaultDepth,
  parameter int unsigned ALMOST_FULL = DefaultAlmostFull,
  localparam int unsigned PtrW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW       = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_valid_i,
  input  logic            pop_ready_i,
  output logic            push_en_o,
  output logic [PtrW-1:0] wptr_o,
  output logic [PtrW-1:0] rptr_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            almost_full_o
);

  localparam logic [PtrW-1:0] PtrLast   = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] CntDepth  = CntW'(DEPTH);
  localparam logic [CntW-1:0] CntAlmost = CntW'(ALMOST_FULL);

  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full_q, full_d, empty_q, empty_d, afull_q, afull_d;
  logic            push, pop;

  assign push = push_valid_i & ~full_q;
  assign pop  = pop_ready_i & ~empty_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    // Explicit wrap compare: DEPTH need not be a power of two.
    if (push) wptr_d = (wptr_q == PtrLast) ? '0 : wptr_q + PtrW'(1);
    if (pop)  rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CntDepth);
    empty_d = (count_d == '0);
    afull_d = (count_d >= CntAlmost);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      afull_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      afull_q <= afull_d;
    end
  end

  assign push_en_o     = push;
  assign wptr_o        = wptr_q;
  assign rptr_o        = rptr_q;
  assign count_o       = count_q;
  assign full_o        = full_q;
  assign empty_o       = empty_q;
  assign almost_full_o = afull_q;

endmodule

// File: rtl/word_stream_fifo.sv
// First-word-fall-through elastic buffer feeding the 10-bit word consumer.
// Storage and read mux live here; pointers and flags come from fifo_ptr_ctrl.
module word_stream_fifo
  import word_stream_pkg::*;
#(
  parameter int unsigned WIDTH       = WordWidth,
  parameter int unsigned DEPTH       = DefaultDepth,
  parameter int unsigned ALMOST_FULL = DefaultAlmostFull,
  localparam int unsigned PtrW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW       = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push_valid,
  output logic             o_push_ready,
  input  logic [WIDTH-1:0] i_push_data,
  output logic             o_pop_valid,
  input  logic             i_pop_ready,
  output logic [WIDTH-1:0] o_pop_data,
  output logic [CntW-1:0]  o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_almost_full
);

  if (DEPTH < 2 || ALMOST_FULL < 1 || ALMOST_FULL > DEPTH) begin : g_param_check
    $fatal(1, "word_stream_fifo: DEPTH must be >= 2 and ALMOST_FULL within 1..DEPTH");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr, rptr;
  logic             push_en;

  fifo_ptr_ctrl #(
    .DEPTH       (DEPTH),
    .ALMOST_FULL (ALMOST_FULL)
  ) u_ctrl (
    .clk_i         (i_clk),
    .rst_i         (i_rst),
    .push_valid_i  (i_push_valid),
    .pop_ready_i   (i_pop_ready),
    .push_en_o     (push_en),
    .wptr_o        (wptr),
    .rptr_o        (rptr),
    .count_o       (o_count),
    .full_o        (o_full),
    .empty_o       (o_empty),
    .almost_full_o (o_almost_full)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_en) begin
      mem_q[wptr] <= i_push_data;
    end
  end

  assign o_push_ready = ~o_full;
  assign o_pop_valid  = ~o_empty;
  assign o_pop_data   = mem_q[rptr];

endmodule

// File: tb/tb_word_stream_fifo.sv
// Scoreboard bench for word_stream_fifo: a queue model tracks accepted words and occupancy
// for a DEPTH=4 and a DEPTH=3 instance; a negedge monitor compares every DUT output.
module tb_word_stream_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DEPTH=4, ALMOST_FULL=3 instance
  logic       rst4, pv4, pr4, prdy4, pval4, full4, empty4, af4;
  logic [9:0] pd4, pdat4;
  logic [2:0] cnt4;
  // DEPTH=3, ALMOST_FULL=2 instance
  logic       rst3, pv3, pr3, prdy3, pval3, full3, empty3, af3;
  logic [9:0] pd3, pdat3;
  logic [1:0] cnt3;

  word_stream_fifo #(.WIDTH(10), .DEPTH(4), .ALMOST_FULL(3)) dut4 (
    .i_clk(clk), .i_rst(rst4), .i_push_valid(pv4), .o_push_ready(prdy4), .i_push_data(pd4),
    .o_pop_valid(pval4), .i_pop_ready(pr4), .o_pop_data(pdat4), .o_count(cnt4),
    .o_full(full4), .o_empty(empty4), .o_almost_full(af4)
  );

  word_stream_fifo #(.WIDTH(10), .DEPTH(3), .ALMOST_FULL(2)) dut3 (
    .i_clk(clk), .i_rst(rst3), .i_push_valid(pv3), .o_push_ready(prdy3), .i_push_data(pd3),
    .o_pop_valid(pval3), .i_pop_ready(pr3), .o_pop_data(pdat3), .o_count(cnt3),
    .o_full(full3), .o_empty(empty3), .o_almost_full(af3)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int depth, input int af, input int sz,
                           input logic [9:0] head, input logic [31:0] cnt, input logic full,
                           input logic empty, input logic afull, input logic prdy,
                           input logic pval, input logic [9:0] pdat);
    cmp({tag, "_count"}, cnt, 32'(sz));
    cmp({tag, "_full"}, 32'(full), 32'(sz == depth));
    cmp({tag, "_empty"}, 32'(empty), 32'(sz == 0));
    cmp({tag, "_almost_full"}, 32'(afull), 32'(sz >= af));
    cmp({tag, "_push_ready"}, 32'(prdy), 32'(sz < depth));
    cmp({tag, "_pop_valid"}, 32'(pval), 32'(sz > 0));
    if (sz > 0) cmp({tag, "_pop_data"}, 32'(pdat), 32'(head));
  endtask

  // Reference model: ordered queue of accepted words per instance.
  logic [9:0] q4[$];
  logic [9:0] q3[$];
  bit         live4 = 1'b0, live3 = 1'b0;

  always @(negedge clk) begin
    if (live4) chk_state("d4", 4, 3, q4.size(), (q4.size() > 0) ? q4[0] : 10'h0, 32'(cnt4),
                         full4, empty4, af4, prdy4, pval4, pdat4);
    if (rst4) begin
      q4.delete();
      live4 = 1'b1;
    end else if (live4) begin
      automatic bit do_pop  = pr4 && (q4.size() > 0);
      automatic bit do_push = pv4 && (q4.size() < 4);
      if (do_pop) void'(q4.pop_front());
      if (do_push) q4.push_back(pd4);
    end

    if (live3) chk_state("d3", 3, 2, q3.size(), (q3.size() > 0) ? q3[0] : 10'h0, 32'(cnt3),
                         full3, empty3, af3, prdy3, pval3, pdat3);
    if (rst3) begin
      q3.delete();
      live3 = 1'b1;
    end else if (live3) begin
      automatic bit do_pop  = pr3 && (q3.size() > 0);
      automatic bit do_push = pv3 && (q3.size() < 3);
      if (do_pop) void'(q3.pop_front());
      if (do_push) q3.push_back(pd3);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv4(input logic r, input logic v, input logic [9:0] d, input logic p);
    rst4 = r; pv4 = v; pd4 = d; pr4 = p;
    tick();
  endtask

  task automatic drv3(input logic r, input logic v, input logic [9:0] d, input logic p);
    rst3 = r; pv3 = v; pd3 = d; pr3 = p;
    tick();
  endtask

  initial begin
    rst4 = 1'b1; pv4 = 1'b1; pd4 = 10'h2AA; pr4 = 1'b0;
    rst3 = 1'b1; pv3 = 1'b0; pd3 = 10'h0;   pr3 = 1'b0;

    // Reset with a push held: nothing may be stored.
    for (int i = 0; i < 3; i++) begin
      drv4(1'b1, 1'b1, 10'h2AA, 1'b0);
      cmp("t1_count", 32'(cnt4), 0);
      cmp("t1_pop_data", 32'(pdat4), 0);
      cmp("t1_push_ready", 32'(prdy4), 1);
    end

    // Fill to full, then a dropped fifth push.
    for (int i = 1; i <= 4; i++) begin
      drv4(1'b0, 1'b1, 10'(i), 1'b0);
      if (i == 3) cmp("t2_almost_full", 32'(af4), 1);
    end
    cmp("t2_full", 32'(full4), 1);
    cmp("t2_push_ready", 32'(prdy4), 0);
    drv4(1'b0, 1'b1, 10'h3FF, 1'b0);
    cmp("t2_count_after_drop", 32'(cnt4), 4);

    // Drain in order.
    for (int i = 1; i <= 4; i++) begin
      cmp("t3_drain_data", 32'(pdat4), 32'(i));
      drv4(1'b0, 1'b0, 10'h0, 1'b1);
    end
    cmp("t3_empty", 32'(empty4), 1);

    // Full with simultaneous push and pop: push rejected.
    for (int i = 5; i <= 8; i++) drv4(1'b0, 1'b1, 10'(i), 1'b0);
    drv4(1'b0, 1'b1, 10'h3FF, 1'b1);
    cmp("t4_count", 32'(cnt4), 3);
    cmp("t4_push_ready", 32'(prdy4), 1);
    cmp("t4_head", 32'(pdat4), 6);
    for (int i = 0; i < 3; i++) drv4(1'b0, 1'b0, 10'h0, 1'b1);

    // Reset mid-burst discards stored words.
    drv4(1'b0, 1'b1, 10'h0AA, 1'b0);
    drv4(1'b0, 1'b1, 10'h0BB, 1'b0);
    cmp("t6_count_before", 32'(cnt4), 2);
    drv4(1'b1, 1'b0, 10'h0, 1'b0);
    cmp("t6_count_after_reset", 32'(cnt4), 0);
    drv4(1'b0, 1'b1, 10'h155, 1'b0);
    cmp("t6_first_word", 32'(pdat4), 32'h155);
    drv4(1'b0, 1'b0, 10'h0, 1'b1);

    // Random traffic with occasional reset.
    for (int i = 0; i < 300; i++)
      drv4(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) != 0),
           10'($urandom_range(0, 1023)), 1'($urandom_range(0, 2) != 0));
    drv4(1'b0, 1'b0, 10'h0, 1'b0);

    // Streaming through DEPTH=3 with pointer wrap.
    drv3(1'b1, 1'b0, 10'h0, 1'b0);
    drv3(1'b0, 1'b1, 10'h000, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      cmp("t5_stream_data", 32'(pdat3), 32'(i - 1));
      drv3(1'b0, 1'b1, 10'(i), 1'b1);
      cmp("t5_count", 32'(cnt3), 1);
    end
    cmp("t5_last", 32'(pdat3), 32'h00F);
    drv3(1'b0, 1'b0, 10'h0, 1'b1);
    cmp("t5_empty", 32'(empty3), 1);

    for (int i = 0; i < 200; i++)
      drv3(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 2) != 0),
           10'($urandom_range(0, 1023)), 1'($urandom_range(0, 3) != 0));
    drv3(1'b0, 1'b0, 10'h0, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
